// File: rtl/fsoc_bench_mon.sv
// rtl/fsoc_bench_mon.sv - benchmark monitor: times the GPO-marked region, counts fetches, reports via Wishbone
module fsoc_bench_mon #(
  parameter int unsigned GPOCNT      = 3,
  parameter int unsigned TIMEOUT     = 1000000,
  // Base the cycle counter starts from on a timed-region rise; 0 in real builds.
  // A nonzero value lets short runs exercise the upper counter word.
  parameter logic [63:0] CYC_PRELOAD = 64'd0
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [GPOCNT-1:0] gpo_i,
  input  logic              ifetch_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_VAL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam bit          TMO_EN    = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST  = TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [63:0] CYC_START = (&CYC_PRELOAD) ? CYC_PRELOAD : CYC_PRELOAD + 64'd1;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CYC_LO = 3'd1;
  localparam logic [2:0] A_CYC_HI = 3'd2;
  localparam logic [2:0] A_FETCH  = 3'd3;
  localparam logic [2:0] A_VAL    = 3'd4;
  localparam logic [2:0] A_CTRL   = 3'd5;

  state_e      state_q, state_d;
  logic        gpo0_q;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] val_q, val_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        tmo_q, tmo_d;
  logic        done_q;
  logic [31:0] snap_q, snap_d;
  logic        ack_q;
  logic [31:0] dat_q, dat_d;

  logic        rise0;
  logic        flag_any;
  logic        access;
  logic        rd_lo;
  logic        clear;
  logic [63:0] cyc_inc;
  logic [31:0] fetch_inc;
  logic [31:0] val_inc;
  logic [31:0] status;
  logic [31:0] rdata;
  logic        unused_dat;

  assign rise0    = gpo_i[0] & ~gpo0_q;
  assign flag_any = gpo_i[1] | gpo_i[2];

  // One ack per access, never back-to-back: a held strobe is acked every other cycle.
  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign rd_lo  = access & ~wb_we_i & (wb_adr_i == A_CYC_LO);
  assign clear  = access & wb_we_i & (wb_adr_i == A_CTRL) & wb_dat_i[0];

  assign unused_dat = ^wb_dat_i[31:1];

  // Saturating increments; counters stick at all-ones instead of wrapping.
  assign cyc_inc   = (&cyc_q)   ? cyc_q   : cyc_q + 64'd1;
  assign fetch_inc = (&fetch_q) ? fetch_q : fetch_q + {31'd0, ifetch_i};
  assign val_inc   = (&val_q)   ? val_q   : val_q + 32'd1;

  assign status = {26'd0, state_q, tmo_q, fail_q, pass_q, done_q};

  // Measurement FSM next state; CLEAR overrides every transition and pending flag.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    fetch_d = fetch_q;
    val_d   = val_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        if (flag_any) begin
          state_d = S_DONE;
          fail_d  = gpo_i[2];
          pass_d  = ~gpo_i[2];
        end else if (rise0) begin
          state_d = S_RUN;
          cyc_d   = CYC_START;
          fetch_d = {31'd0, ifetch_i};
        end
      end
      S_RUN: begin
        if (flag_any) begin
          state_d = S_DONE;
          val_d   = 32'd0;
          fail_d  = gpo_i[2];
          pass_d  = ~gpo_i[2];
        end else if (gpo_i[0]) begin
          cyc_d   = cyc_inc;
          fetch_d = fetch_inc;
        end else begin
          state_d = S_VAL;
          val_d   = 32'd0;
        end
      end
      S_VAL: begin
        if (flag_any) begin
          state_d = S_DONE;
          val_d   = val_inc;
          fail_d  = gpo_i[2];
          pass_d  = ~gpo_i[2];
        end else if (TMO_EN && (val_q == TMO_LAST)) begin
          state_d = S_DONE;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          val_d = val_inc;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
    if (rd_lo) begin
      snap_d = cyc_q[63:32];
    end
    if (clear) begin
      state_d = S_IDLE;
      cyc_d   = 64'd0;
      fetch_d = 32'd0;
      val_d   = 32'd0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      tmo_d   = 1'b0;
      snap_d  = 32'd0;
    end
  end

  // Register read mux; unmapped and write-only addresses read as zero.
  always_comb begin
    rdata = 32'd0;
    case (wb_adr_i)
      A_STATUS: rdata = status;
      A_CYC_LO: rdata = cyc_q[31:0];
      A_CYC_HI: rdata = snap_q;
      A_FETCH:  rdata = fetch_q;
      A_VAL:    rdata = val_q;
      default:  rdata = 32'd0;
    endcase
    dat_d = (access & ~wb_we_i) ? rdata : 32'd0;
  end

  // State, counters, flags and bus outputs; reset aborts any run at once.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      gpo0_q  <= 1'b0;
      cyc_q   <= 64'd0;
      fetch_q <= 32'd0;
      val_q   <= 32'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      snap_q  <= 32'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      gpo0_q  <= gpo_i[0];
      cyc_q   <= cyc_d;
      fetch_q <= fetch_d;
      val_q   <= val_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      done_q  <= (state_d == S_DONE);
      snap_q  <= snap_d;
      ack_q   <= access;
      dat_q   <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign done_o   = done_q;
  assign pass_o   = pass_q;
  assign fail_o   = fail_q;

endmodule
